// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Two-master arbiter for a single-port program memory.
//                m0 = instruction fetch (read only), m1 = loader/debug
//                (read/write, with a bounded burst lock). One access is
//                granted per cycle; read data returns one cycle later and
//                is steered to the master that issued the read.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters  : ADDR_W    word-address width
//                DATA_W    data width
//                MAX_BURST max consecutive locked m1 grants while m0 waits
//  Ports       : clk, rst            clock, async active-high reset
//                m0_req/addr         fetch request  -> m0_gnt
//                m0_rvalid/rdata     fetch read return
//                m1_req/we/addr/wdata/lock  loader request -> m1_gnt
//                m1_rvalid/rdata     loader read return
//                mem_en/we/addr/wdata, mem_rdata   memory macro side
//                stall_cnt           fetch stall counter
//  Build macro : ARB_STALL_CNT_EN  enables the saturating stall counter;
//                when undefined stall_cnt is tied to zero.
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  localparam int              BW      = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]   C_MAX_B = BW'(MAX_BURST);
  localparam logic [BW-1:0]   C_ONE   = BW'(1);

  logic          last_q, last_d;          // 0 = m0 won last, 1 = m1
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_owner_q, rd_owner_d;
  logic          pick_m1;

  // Arbitration and memory strobes. Grants are forced low while rst is
  // high so nothing reaches the memory during reset.
  always_comb begin
    pick_m1   = 1'b0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = m0_addr;
    mem_wdata = m1_wdata;

    if (m0_req && m1_req) begin
      // Lock keeps m1 only while it owns the port and has budget left.
      if (last_q && m1_lock && (burst_cnt_q < C_MAX_B))
        pick_m1 = 1'b1;
      else
        pick_m1 = !last_q;
    end else begin
      pick_m1 = m1_req;
    end

    if (!rst) begin
      m1_gnt = m1_req && pick_m1;
      m0_gnt = m0_req && !pick_m1;
    end

    if (m1_gnt) begin
      mem_en   = 1'b1;
      mem_we   = m1_we;
      mem_addr = m1_addr;
    end else if (m0_gnt) begin
      mem_en   = 1'b1;
    end
  end

  // Next-state for winner history, burst budget and read return tag.
  always_comb begin
    last_d      = last_q;
    burst_cnt_d = '0;
    rd_pend_d   = 1'b0;
    rd_owner_d  = rd_owner_q;

    if (m1_gnt)
      last_d = 1'b1;
    else if (m0_gnt)
      last_d = 1'b0;

    // Counter only survives through consecutive locked m1 grants.
    if (m1_gnt && m1_lock)
      burst_cnt_d = (burst_cnt_q == C_MAX_B) ? C_MAX_B : burst_cnt_q + C_ONE;

    if (m0_gnt) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = 1'b0;
    end else if (m1_gnt && !m1_we) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
    end else begin
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
    end
  end

  assign m0_rvalid = rd_pend_q && !rd_owner_q;
  assign m1_rvalid = rd_pend_q &&  rd_owner_q;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m0_req && !m0_gnt && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= 16'd0;
    else
      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed bench for mem_port_arbiter with a synchronous
//                memory model and a read-return scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req;
  logic [11:0] m0_addr;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic        m1_we;
  logic [11:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_lock;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] stall_cnt;

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory macro model and an independent reference image.
  logic [31:0] mem_arr [0:4095];
  logic [31:0] ref_mem [0:4095];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  int passes = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Scoreboard: {owner, data} pushed at each read grant, popped at rvalid.
  logic [32:0] sbq [$];

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      sbq.delete();
    end else begin
      if (m0_rvalid || m1_rvalid) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("rv_owner", 32'({m1_rvalid, m0_rvalid}), e[32] ? 32'd2 : 32'd1);
          chk("rdata", e[32] ? m1_rdata : m0_rdata, e[31:0]);
        end
      end
      if (m0_gnt && m1_gnt) chk("gnt_onehot", 32'd1, 32'd0);
      if (m0_gnt) begin
        chk("m0_mem_addr", 32'(mem_addr), 32'(m0_addr));
        chk("m0_mem_we", 32'(mem_we), 32'd0);
        sbq.push_back({1'b0, ref_mem[m0_addr]});
      end
      if (m1_gnt) begin
        chk("m1_mem_addr", 32'(mem_addr), 32'(m1_addr));
        chk("m1_mem_we", 32'(mem_we), 32'(m1_we));
        if (m1_we) begin
          chk("m1_mem_wdata", mem_wdata, m1_wdata);
          ref_mem[m1_addr] = m1_wdata;
        end else begin
          sbq.push_back({1'b1, ref_mem[m1_addr]});
        end
      end
    end
  end

  // Single request, held until granted (bounded), then released.
  task automatic issue(input bit port, input bit we, input logic [11:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = 1'b0;
    end else begin
      m0_req = 1'b1; m0_addr = a;
    end
    for (int i = 0; i < 32 && !got; i++) begin
      @(negedge clk);
      got = port ? m1_gnt : m0_gnt;
      if (!got) begin @(posedge clk); #1; end
    end
    chk("issue_gnt_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    if (port) m1_req = 1'b0; else m0_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0;
    @(negedge clk);
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [15:0] snap;
  int          k;
  logic        g0, g1;
  logic [15:0] exp_stall;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_arr[i] = 32'hA5000000 | 32'(i);
      ref_mem[i] = 32'hA5000000 | 32'(i);
    end
    mem_arr[4] = 32'h00500093;
    ref_mem[4] = 32'h00500093;
    rst = 1'b1;
    m0_req = 1'b0; m0_addr = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // ROM fetch after reset release.
    m0_req = 1'b1; m0_addr = 12'h004;
    @(negedge clk);
    chk("t1_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("t1_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    chk("t1_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("t1_m0_rdata", m0_rdata, 32'h00500093);
    chk("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);
    @(posedge clk); #1;

    // Unlocked contention: strict alternation, m0 first after reset.
    do_reset();
    m0_req = 1'b1; m0_addr = 12'h030;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h040; m1_lock = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t2_m0_gnt", 32'(m0_gnt), 32'(c % 2 == 0));
      chk("t2_m1_gnt", 32'(m1_gnt), 32'(c % 2 == 1));
      g0 = m0_gnt; g1 = m1_gnt;
      @(posedge clk); #1;
      if (g0) m0_addr = m0_addr + 12'd1;
      if (g1) m1_addr = m1_addr + 12'd1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;

    // Locked 12-word write burst against continuous fetch.
    k = 0;
    m0_req = 1'b1; m0_addr = 12'h010;
    m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b1;
    m1_addr = 12'h100; m1_wdata = 32'hC0DE0000;
    snap = 16'd0;
`ifdef ARB_STALL_CNT_EN
    exp_stall = 16'd8;
`else
    exp_stall = 16'd0;
`endif
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c == 0) snap = stall_cnt;
      chk("t3_m1_gnt", 32'(m1_gnt), 32'(c != 8));
      chk("t3_m0_gnt", 32'(m0_gnt), 32'(c == 8));
      if (c == 8) chk("t3_stall_cnt_delta", 32'(stall_cnt - snap), 32'(exp_stall));
      g0 = m0_gnt; g1 = m1_gnt;
      @(posedge clk); #1;
      if (g1) begin
        k++;
        if (k == 12) begin
          m1_req = 1'b0; m1_lock = 1'b0;
        end else begin
          m1_addr = 12'h100 + 12'(k);
          m1_wdata = 32'hC0DE0000 + 32'(k);
        end
      end
      if (g0) m0_addr = m0_addr + 12'd1;
    end
    chk("t3_burst_words", 32'(k), 32'd12);
    @(negedge clk);
    chk("t3_m0_after_burst", 32'(m0_gnt), 32'd1);
    @(posedge clk); #1;
    m0_req = 1'b0;

    // Readback of the burst region.
    for (int i = 0; i < 12; i++) issue(1'b1, 1'b0, 12'h100 + 12'(i), 32'd0);
    @(posedge clk); #1;

    // Write followed immediately by a read of the same word.
    issue(1'b1, 1'b1, 12'h020, 32'hDEADBEEF);
    issue(1'b0, 1'b0, 12'h020, 32'd0);
    @(negedge clk);
    chk("t4_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("t4_m0_rdata", m0_rdata, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Reset lands in the cycle of a granted read.
    m0_req = 1'b1; m0_addr = 12'h004;
    @(negedge clk);
    chk("t5_m0_gnt", 32'(m0_gnt), 32'd1);
    #2;
    rst = 1'b1; m0_req = 1'b0;
    #1;
    chk("t5_mem_en_in_rst", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    chk("t5_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("t5_stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m0_req = 1'b1; m0_addr = 12'h008;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h009; m1_lock = 1'b0;
    @(negedge clk);
    chk("t5_m0_rvalid_after", 32'(m0_rvalid), 32'd0);
    chk("t5_tie_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("t5_tie_m1_gnt", 32'(m1_gnt), 32'd0);
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    chk("t5_m1_gnt_next", 32'(m1_gnt), 32'd1);
    @(posedge clk); #1;
    m1_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
